// File: rtl/mips_trace_monitor.sv
// rtl/mips_trace_monitor.sv - commit-trace FIFO with run-complete and watchdog detection
// Optional feature macro: TRACE_OVERWRITE_EN (circular trace keeping the newest DEPTH records).
module mips_trace_monitor #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 16,
  parameter int STALL_LIMIT    = 2,
  parameter int TIMEOUT_CYCLES = 500,
  localparam int REC_W         = 2*ADDR_W + 2*DATA_W + 39,
  localparam int CNT_W         = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [REC_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              done,
  output logic              timeout
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int STALL_W = $clog2(STALL_LIMIT+1);
  localparam int CYC_W   = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [31:0] HALT_INSTR = 32'h0000_000C;

  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [REC_W-1:0]   rec;
  logic               mem_we;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [ADDR_W-1:0]  prev_pc_q, prev_pc_d;
  logic               have_prev_q, have_prev_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;

  logic               push;
  logic               pop;
  logic               full;
  logic [STALL_W-1:0] stall_next;

  assign rec      = {pc, instr, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata};
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

  // Next-state for FIFO pointers, sticky flags, stall detector and watchdog
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    stall_d     = stall_q;
    prev_pc_d   = prev_pc_q;
    have_prev_d = have_prev_q;
    cyc_d       = cyc_q;
    mem_we      = 1'b0;
    stall_next  = '0;

    push = enable && !done_q && !timeout_q;
    pop  = rd_valid && rd_ready;
    full = (count_q == CNT_W'(DEPTH));

    if (push && pop) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (push) begin
      if (!full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
`ifdef TRACE_OVERWRITE_EN
        // When full, wr_ptr equals rd_ptr, so this write replaces the oldest record.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
`endif
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end

    if (push) begin
      if (have_prev_q && (pc == prev_pc_q)) begin
        stall_next = (stall_q == STALL_W'(STALL_LIMIT)) ? stall_q : stall_q + STALL_W'(1);
      end
      stall_d     = stall_next;
      prev_pc_d   = pc;
      have_prev_d = 1'b1;
      if ((instr == HALT_INSTR) || (stall_next >= STALL_W'(STALL_LIMIT))) begin
        done_d = 1'b1;
      end
    end

    // Watchdog counts the same qualified cycles; done on the same edge takes priority.
    if (enable && !done_q && !timeout_q) begin
      if (cyc_q != CYC_W'(TIMEOUT_CYCLES)) begin
        cyc_d = cyc_q + CYC_W'(1);
      end
      if ((cyc_d == CYC_W'(TIMEOUT_CYCLES)) && !done_d) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
      prev_pc_q   <= '0;
      have_prev_q <= 1'b0;
      cyc_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      prev_pc_q   <= prev_pc_d;
      have_prev_q <= have_prev_d;
      cyc_q       <= cyc_d;
    end
  end

  // Trace storage; contents are masked by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= rec;
    end
  end

endmodule
